apb_slave_mem: RTL and testbench

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem.sv | 167 ++++++++++++++++
 tb/tb_apb_slave_mem.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave backed by a small register-file memory.
// Two-state FSM (IDLE/ACCESS).
// Setup-phase fields are latched, so later bus changes do not affect a transfer.
// pready, pslverr and pr_data are all registered outputs.
// Optional macro APB_SLV_WAIT_EN builds a wait counter that holds pready low
// for WAIT_STATES access cycles.
// Without the macro every transfer completes with zero wait states.
module apb_slave_mem #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pw_data,
    output logic [DATA_W-1:0] pr_data,
    output logic              pready,
    output logic              pslverr
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Elaboration-time parameter sanity checks
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("apb_slave_mem: WAIT_STATES must be 0..15");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("apb_slave_mem: DEPTH must be 1..2**ADDR_W");
    end

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   pr_data_q, pr_data_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
`ifdef APB_SLV_WAIT_EN
    logic [3:0]          cnt_q, cnt_d;
`endif

    // Response is built from whichever address/direction is current when
    // pready rises: the live bus on the setup edge, the latched copy later.
    logic                set_rdy;
    logic [ADDR_W-1:0]   rdy_addr;
    logic                rdy_wr;

    // Zero-extend by one bit so DEPTH == 2**ADDR_W still compares correctly
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W + 1)'(DEPTH));
    endfunction

    // Next-state, wait counting, response and memory-commit logic
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        pr_data_d = pr_data_q;
        mem_d     = mem_q;
        set_rdy   = 1'b0;
        rdy_addr  = addr_q;
        rdy_wr    = write_q;
`ifdef APB_SLV_WAIT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // penable without a setup phase falls through untouched
                if (psel && !penable) begin
                    state_d  = ACCESS;
                    addr_d   = paddr;
                    write_d  = pwrite;
                    wdata_d  = pw_data;
                    rdy_addr = paddr;
                    rdy_wr   = pwrite;
`ifdef APB_SLV_WAIT_EN
                    cnt_d = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) set_rdy  = 1'b1;
                    else                  pready_d = 1'b0;
`else
                    set_rdy = 1'b1;
`endif
                end
            end
            ACCESS: begin
                if (!psel) begin
                    // Abort: drop the transfer, nothing is written
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
`ifdef APB_SLV_WAIT_EN
                    cnt_d     = 4'd0;
`endif
                end else if (penable) begin
                    if (pready_q) begin
                        if (write_q && in_range(addr_q))
                            mem_d[addr_q[IDX_W-1:0]] = wdata_q;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        state_d   = IDLE;
                    end
`ifdef APB_SLV_WAIT_EN
                    else if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        set_rdy = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (set_rdy) begin
            pready_d  = 1'b1;
            pslverr_d = !in_range(rdy_addr);
            if (!rdy_wr)
                pr_data_d = in_range(rdy_addr) ? mem_q[rdy_addr[IDX_W-1:0]] : '0;
        end
    end

    // State registers; reset clears the whole memory as well
    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            pr_data_q <= '0;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= 4'd0;
`endif
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            pr_data_q <= pr_data_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= cnt_d;
`endif
            mem_q     <= mem_d;
        end
    end

    assign pr_data = pr_data_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: a zero-wait instance and a WAIT_STATES=3 instance
// share one APB bus, steered by dsel.
module tb_apb_slave_mem;
`ifdef APB_SLV_WAIT_EN
    localparam int WEXP3 = 3;
`else
    localparam int WEXP3 = 0;
`endif

    logic       clk = 1'b0;
    logic       preset = 1'b0;
    logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0] paddr = '0, pw_data = '0;
    int         dsel = 0;

    logic       psel0, psel3, pready0, pready3, pslverr0, pslverr3;
    logic [7:0] prd0, prd3;
    logic       rdy_m, err_m;
    logic [7:0] prd_m;

    assign psel0 = psel && (dsel == 0);
    assign psel3 = psel && (dsel == 1);
    assign rdy_m = (dsel == 1) ? pready3  : pready0;
    assign err_m = (dsel == 1) ? pslverr3 : pslverr0;
    assign prd_m = (dsel == 1) ? prd3     : prd0;

    apb_slave_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .preset(preset), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pw_data(pw_data),
        .pr_data(prd0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_slave_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .preset(preset), .psel(psel3), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pw_data(pw_data),
        .pr_data(prd3), .pready(pready3), .pslverr(pslverr3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic       is_rd;
        logic [7:0] rd;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full transfer starting at a negedge; returns at the negedge after
    // the completion edge so a following call runs back-to-back.
    task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd,
                        input logic exp_err, input int exp_wait);
        int   t0;
        int   waits;
        exp_t e;
        dsel    = d;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pw_data = wd;
        e.is_rd = !wr;
        e.rd    = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        t0 = cyc;
        @(negedge clk);
        // Scramble the bus after setup; the slave must use its latched copy
        penable = 1'b1;
        paddr   = ~a;
        pw_data = ~wd;
        pwrite  = !wr;
        waits   = 0;
        while (!rdy_m && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        chk("wait_cycles", waits, exp_wait);
        e = sb.pop_front();
        chk("pslverr", err_m, e.err);
        if (e.is_rd) chk("pr_data", prd_m, e.rd);
        @(negedge clk);
        chk("xfer_cycles", cyc - t0, 2 + exp_wait);
        chk("pready_clr", rdy_m, 1'b0);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[16];
        logic [7:0] wv[6];
        wv = '{8'h7B, 8'h57, 8'hC8, 8'h2D, 8'hB2, 8'h63};

        for (int i = 0; i < 6; i++) begin
            tbl[i]     = '{wr: 1'b1, addr: 8'(i), wdata: wv[i], exp_rd: 8'h00, exp_err: 1'b0};
            tbl[i + 6] = '{wr: 1'b0, addr: 8'(i), wdata: 8'h00, exp_rd: wv[i], exp_err: 1'b0};
        end
        tbl[12] = '{wr: 1'b1, addr: 8'h17, wdata: 8'hAF, exp_rd: 8'h00, exp_err: 1'b1};
        tbl[13] = '{wr: 1'b0, addr: 8'h17, wdata: 8'h00, exp_rd: 8'h00, exp_err: 1'b1};
        tbl[14] = '{wr: 1'b0, addr: 8'h07, wdata: 8'h00, exp_rd: 8'h00, exp_err: 1'b0};
        tbl[15] = '{wr: 1'b0, addr: 8'h05, wdata: 8'h00, exp_rd: 8'h63, exp_err: 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pready0",  pready0,  1'b0);
        chk("rst_pslverr0", pslverr0, 1'b0);
        chk("rst_prdata0",  prd0,     8'h00);
        chk("rst_pready3",  pready3,  1'b0);
        chk("rst_prdata3",  prd3,     8'h00);
        preset = 1'b1;

        // Write/readback, out-of-range write and reads
        for (int i = 0; i < 16; i++)
            xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err, 0);

        // penable without setup in IDLE is ignored
        dsel = 0; psel = 1'b1; penable = 1'b1;
        repeat (3) @(negedge clk);
        chk("noset_pready",  pready0,  1'b0);
        chk("noset_pslverr", pslverr0, 1'b0);
        chk("noset_prdata",  prd0,     8'h63);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);

        // Wait states on the WAIT_STATES=3 instance
        xfer(1, 1'b1, 8'd2, 8'h55, 8'h00, 1'b0, WEXP3);
        xfer(1, 1'b0, 8'd2, 8'h00, 8'h55, 1'b0, WEXP3);
        xfer(1, 1'b1, 8'd4, 8'h11, 8'h00, 1'b0, WEXP3);

        // Abort in the first access cycle
        dsel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd4; pw_data = 8'hEE;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort_pready",  pready3,  1'b0);
        chk("abort_pslverr", pslverr3, 1'b0);
        xfer(1, 1'b0, 8'd4, 8'h00, 8'h11, 1'b0, WEXP3);

        // Asynchronous reset mid-access
        xfer(0, 1'b0, 8'd0, 8'h00, 8'h7B, 1'b0, 0);
        dsel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd3; pw_data = 8'h99;
        @(negedge clk);
        penable = 1'b1;
        chk("prerst_pready", pready0, 1'b1);
        #2 preset = 1'b0;
        #1;
        chk("arst_pready",  pready0,  1'b0);
        chk("arst_pslverr", pslverr0, 1'b0);
        chk("arst_prdata0", prd0,     8'h00);
        chk("arst_prdata3", prd3,     8'h00);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        preset = 1'b1;
        for (int i = 0; i < 6; i++) xfer(0, 1'b0, 8'(i), 8'h00, 8'h00, 1'b0, 0);
        xfer(1, 1'b0, 8'd2, 8'h00, 8'h00, 1'b0, WEXP3);
        xfer(1, 1'b0, 8'd4, 8'h00, 8'h00, 1'b0, WEXP3);

        // Back-to-back writes, no idle cycle between them
        xfer(0, 1'b1, 8'd0, 8'hA1, 8'h00, 1'b0, 0);
        xfer(0, 1'b1, 8'd1, 8'hB2, 8'h00, 1'b0, 0);
        xfer(0, 1'b0, 8'd0, 8'h00, 8'hA1, 1'b0, 0);
        xfer(0, 1'b0, 8'd1, 8'h00, 8'hB2, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
